// File: rtl/inst_fetch_if.sv
// Fetch-side bus bundle: instruction memory request/response, redirect
// input from branch resolution and the decode-facing instruction port.
interface inst_fetch_if #(
  parameter int WIDTH_INST_LENGTH = 32,
  parameter int WIDTH_ADDR_LENGTH = 32
);
  logic                         IReqValid;
  logic                         IReqReady;
  logic [WIDTH_ADDR_LENGTH-1:0] IReqAddr;
  logic                         IRespValid;
  logic [WIDTH_INST_LENGTH-1:0] IRespData;
  logic                         Redirect;
  logic [WIDTH_ADDR_LENGTH-1:0] RedirectPc;
  logic [WIDTH_INST_LENGTH-1:0] Inst;
  logic [WIDTH_ADDR_LENGTH-1:0] InstPc;
  logic                         InstValid;
  logic                         InstReady;

  // The fetch unit itself
  modport master (
    output IReqValid, IReqAddr, Inst, InstPc, InstValid,
    input  IReqReady, IRespValid, IRespData, Redirect, RedirectPc, InstReady
  );

  // Memory, redirect source and decode seen together from outside
  modport slave (
    input  IReqValid, IReqAddr, Inst, InstPc, InstValid,
    output IReqReady, IRespValid, IRespData, Redirect, RedirectPc, InstReady
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: keeps the fetch PC, issues in-order word requests,
// buffers returned words in a small queue and hands {Inst, InstPc} to decode.
// A redirect empties the queue and arranges for in-flight responses to be
// thrown away as they come back.
module inst_fetch #(
  parameter int                            WIDTH_INST_LENGTH = 32,
  parameter int                            WIDTH_ADDR_LENGTH = 32,
  parameter logic [WIDTH_ADDR_LENGTH-1:0]  RESET_PC          = '0,
  parameter int                            DEPTH             = 2
) (
  input  logic         Clk,
  input  logic         Rst,
  inst_fetch_if.master bus
);

  localparam int IW = WIDTH_INST_LENGTH;
  localparam int AW = WIDTH_ADDR_LENGTH;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [IW-1:0] inst_mem_q [DEPTH];
  logic [IW-1:0] inst_mem_d [DEPTH];
  logic [AW-1:0] pc_mem_q [DEPTH];
  logic [AW-1:0] pc_mem_d [DEPTH];

  logic          req_valid;
  logic          req_fire;
  logic          resp_in;
  logic          push;
  logic          inst_valid;
  logic          pop;
  logic [CW:0]   credit_used;
  logic [AW-1:0] redirect_target;

  // Handshake qualifiers: credit uses registered occupancy only so the
  // queue can never overflow, and a redirect suppresses both request and head
  always_comb begin
    credit_used     = {1'b0, outstanding_q} + {1'b0, count_q};
    req_valid       = !Rst && !bus.Redirect && (credit_used < DEPTH_C);
    req_fire        = req_valid && bus.IReqReady;
    resp_in         = bus.IRespValid && (outstanding_q != '0);
    push            = resp_in && (drop_cnt_q == '0) && !bus.Redirect;
    inst_valid      = !Rst && !bus.Redirect && (count_q != '0);
    pop             = inst_valid && bus.InstReady;
    redirect_target = bus.RedirectPc & ~AW'(3);
  end

  assign bus.IReqValid = req_valid;
  assign bus.IReqAddr  = fetch_pc_q;
  assign bus.InstValid = inst_valid;
  assign bus.Inst      = inst_mem_q[rd_ptr_q];
  assign bus.InstPc    = pc_mem_q[rd_ptr_q];

  // Next-state: redirect overrides everything, otherwise issue/response/pop
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      inst_mem_d[i] = inst_mem_q[i];
      pc_mem_d[i]   = pc_mem_q[i];
    end

    if (bus.Redirect) begin
      fetch_pc_d    = redirect_target;
      resp_pc_d     = redirect_target;
      outstanding_d = outstanding_q - CW'(resp_in);
      drop_cnt_d    = outstanding_q - CW'(resp_in);
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + AW'(4);
      end
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_in);
      if (resp_in && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (push) begin
        inst_mem_d[wr_ptr_q] = bus.IRespData;
        pc_mem_d[wr_ptr_q]   = resp_pc_q;
        wr_ptr_d             = wr_ptr_q + PW'(1);
        resp_pc_d            = resp_pc_q + AW'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State registers with synchronous reset; queue storage is cleared so the
  // head reads as {0, RESET_PC} straight out of reset
  always_ff @(posedge Clk) begin
    if (Rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= RESET_PC;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= inst_mem_d[i];
        pc_mem_q[i]   <= pc_mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: two instances (RESET_PC 0 and 0xFFFF_FFFC),
// an in-order memory model with adjustable latency returning addr ^ 0xA5A5_0000.
module tb_inst_fetch;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  inst_fetch_if bus0 ();
  inst_fetch_if bus1 ();

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut0 (.Clk(clk), .Rst(rst), .bus(bus0));
  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut1 (.Clk(clk), .Rst(rst), .bus(bus1));

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        mem_q [$];
  int          cyc = 0;
  int          mem_lat = 1;
  logic        pend1 = 1'b0;
  logic [31:0] pend_addr1 = '0;

  logic [31:0] req_log0 [$];
  logic [31:0] pop_pc0 [$];
  logic [31:0] pop_inst0 [$];
  logic [31:0] req_log1 [$];
  logic [31:0] pop_pc1 [$];
  logic [31:0] pop_inst1 [$];

  int tests_run = 0;
  int tests_failed = 0;

  // Memory models drive responses just after each rising edge
  initial begin
    bus0.IRespValid = 1'b0;
    bus0.IRespData  = '0;
    bus1.IRespValid = 1'b0;
    bus1.IRespData  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        bus0.IRespValid = 1'b1;
        bus0.IRespData  = mem_q[0].addr ^ 32'hA5A5_0000;
        void'(mem_q.pop_front());
      end else begin
        bus0.IRespValid = 1'b0;
        bus0.IRespData  = '0;
      end
      bus1.IRespValid = pend1;
      bus1.IRespData  = pend_addr1 ^ 32'hA5A5_0000;
      pend1 = 1'b0;
    end
  end

  // Observe accepted requests and pops mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      mem_q.delete();
      pend1 = 1'b0;
    end else begin
      if (bus0.IReqValid && bus0.IReqReady) begin
        mem_q.push_back('{bus0.IReqAddr, cyc + mem_lat});
        req_log0.push_back(bus0.IReqAddr);
      end
      if (bus0.InstValid && bus0.InstReady) begin
        pop_pc0.push_back(bus0.InstPc);
        pop_inst0.push_back(bus0.Inst);
      end
      if (bus1.IReqValid && bus1.IReqReady) begin
        pend1      = 1'b1;
        pend_addr1 = bus1.IReqAddr;
        req_log1.push_back(bus1.IReqAddr);
      end
      if (bus1.InstValid && bus1.InstReady) begin
        pop_pc1.push_back(bus1.InstPc);
        pop_inst1.push_back(bus1.Inst);
      end
    end
  end

  function automatic logic [31:0] q_at(input logic [31:0] q [$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_DEAD;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic inst_ready, input int lat);
    rst            = r;
    bus0.InstReady = inst_ready;
    mem_lat        = lat;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    req_log0.delete();
    pop_pc0.delete();
    pop_inst0.delete();
  endtask

  // Directed sequence covering reset, streaming, backpressure, redirect, wrap
  initial begin
    int seq_err;
    rst             = 1'b1;
    bus0.IReqReady  = 1'b1;
    bus0.InstReady  = 1'b1;
    bus0.Redirect   = 1'b0;
    bus0.RedirectPc = '0;
    bus1.IReqReady  = 1'b1;
    bus1.InstReady  = 1'b1;
    bus1.Redirect   = 1'b0;
    bus1.RedirectPc = '0;

    // Reset values
    tick(2);
    @(negedge clk);
    checkOutput("rst_ireq_valid", 32'(bus0.IReqValid), 32'd0);
    checkOutput("rst_inst_valid", 32'(bus0.InstValid), 32'd0);

    // Streaming with 1-cycle memory
    tick(1);
    applyStimulus(1'b0, 1'b1, 1);
    clear_logs();
    @(negedge clk);
    checkOutput("t1_ireq_valid0", 32'(bus0.IReqValid), 32'd1);
    checkOutput("t1_ireq_addr0", bus0.IReqAddr, 32'h0);
    checkOutput("t1_inst_valid0", 32'(bus0.InstValid), 32'd0);
    checkOutput("t1_inst_pc0", bus0.InstPc, 32'h0);
    checkOutput("t1_inst0", bus0.Inst, 32'h0);
    checkOutput("t1_dut1_addr0", bus1.IReqAddr, 32'hFFFF_FFFC);
    tick(12);
    checkOutput("t1_req0", q_at(req_log0, 0), 32'h0);
    checkOutput("t1_req1", q_at(req_log0, 1), 32'h4);
    checkOutput("t1_req2", q_at(req_log0, 2), 32'h8);
    checkOutput("t1_pc0", q_at(pop_pc0, 0), 32'h0);
    checkOutput("t1_inst0p", q_at(pop_inst0, 0), 32'hA5A5_0000);
    checkOutput("t1_pc1", q_at(pop_pc0, 1), 32'h4);
    checkOutput("t1_inst1p", q_at(pop_inst0, 1), 32'hA5A5_0004);
    checkOutput("t1_pc2", q_at(pop_pc0, 2), 32'h8);
    checkOutput("t1_enough_pops", 32'(pop_pc0.size() >= 3), 32'd1);
    seq_err = 0;
    for (int i = 1; i < pop_pc0.size(); i++) begin
      if (pop_pc0[i] != pop_pc0[i-1] + 32'd4) seq_err++;
      if (pop_inst0[i] != (pop_pc0[i] ^ 32'hA5A5_0000)) seq_err++;
    end
    checkOutput("t1_no_dup_order", 32'(seq_err), 32'd0);
    checkOutput("wrap_req0", q_at(req_log1, 0), 32'hFFFF_FFFC);
    checkOutput("wrap_req1", q_at(req_log1, 1), 32'h0);
    checkOutput("wrap_pc0", q_at(pop_pc1, 0), 32'hFFFF_FFFC);
    checkOutput("wrap_inst0", q_at(pop_inst1, 0), 32'h5A5A_FFFC);
    checkOutput("wrap_pc1", q_at(pop_pc1, 1), 32'h0);
    checkOutput("wrap_inst1", q_at(pop_inst1, 1), 32'hA5A5_0000);

    // Decode stalled from reset: two requests fill the queue, then stop
    applyStimulus(1'b1, 1'b0, 1);
    @(negedge clk);
    checkOutput("t2_rst_ireq", 32'(bus0.IReqValid), 32'd0);
    checkOutput("t2_rst_inst", 32'(bus0.InstValid), 32'd0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1);
    clear_logs();
    tick(8);
    @(negedge clk);
    checkOutput("t2_req_count", 32'(req_log0.size()), 32'd2);
    checkOutput("t2_req0", q_at(req_log0, 0), 32'h0);
    checkOutput("t2_req1", q_at(req_log0, 1), 32'h4);
    checkOutput("t2_ireq_idle", 32'(bus0.IReqValid), 32'd0);
    checkOutput("t2_head_valid", 32'(bus0.InstValid), 32'd1);
    checkOutput("t2_head_pc", bus0.InstPc, 32'h0);
    checkOutput("t2_head_inst", bus0.Inst, 32'hA5A5_0000);
    tick(1);
    bus0.InstReady = 1'b1;
    clear_logs();
    tick(6);
    checkOutput("t2_pop0", q_at(pop_pc0, 0), 32'h0);
    checkOutput("t2_pop1", q_at(pop_pc0, 1), 32'h4);
    checkOutput("t2_resume", q_at(req_log0, 0), 32'h8);

    // Redirect with two requests in flight on a 3-cycle memory
    applyStimulus(1'b1, 1'b1, 3);
    tick(1);
    applyStimulus(1'b0, 1'b1, 3);
    tick(2);
    bus0.Redirect   = 1'b1;
    bus0.RedirectPc = 32'h0000_0103;
    clear_logs();
    @(negedge clk);
    checkOutput("t3_redir_ireq", 32'(bus0.IReqValid), 32'd0);
    checkOutput("t3_redir_inst", 32'(bus0.InstValid), 32'd0);
    tick(1);
    bus0.Redirect = 1'b0;
    tick(15);
    checkOutput("t3_req0", q_at(req_log0, 0), 32'h100);
    checkOutput("t3_pc0", q_at(pop_pc0, 0), 32'h100);
    checkOutput("t3_inst0", q_at(pop_inst0, 0), 32'hA5A5_0100);
    checkOutput("t3_pc1", q_at(pop_pc0, 1), 32'h104);

    // Redirect in the same cycle a response arrives
    applyStimulus(1'b1, 1'b1, 1);
    tick(1);
    applyStimulus(1'b0, 1'b1, 1);
    tick(1);
    bus0.Redirect   = 1'b1;
    bus0.RedirectPc = 32'h0000_0200;
    clear_logs();
    @(negedge clk);
    checkOutput("t4_redir_inst", 32'(bus0.InstValid), 32'd0);
    checkOutput("t4_redir_ireq", 32'(bus0.IReqValid), 32'd0);
    tick(1);
    bus0.Redirect = 1'b0;
    @(negedge clk);
    checkOutput("t4_ireq_valid", 32'(bus0.IReqValid), 32'd1);
    checkOutput("t4_ireq_addr", bus0.IReqAddr, 32'h200);
    checkOutput("t4_no_stale", 32'(bus0.InstValid), 32'd0);
    tick(1);
    @(negedge clk);
    checkOutput("t4_not_yet", 32'(bus0.InstValid), 32'd0);
    tick(1);
    @(negedge clk);
    checkOutput("t4_valid", 32'(bus0.InstValid), 32'd1);
    checkOutput("t4_pc", bus0.InstPc, 32'h200);
    checkOutput("t4_inst", bus0.Inst, 32'hA5A5_0200);

    // Reset pulse with a full queue
    tick(1);
    applyStimulus(1'b1, 1'b0, 1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1);
    tick(6);
    @(negedge clk);
    checkOutput("t5_full", 32'(bus0.InstValid), 32'd1);
    tick(1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5_rst_ireq", 32'(bus0.IReqValid), 32'd0);
    checkOutput("t5_rst_inst", 32'(bus0.InstValid), 32'd0);
    tick(1);
    applyStimulus(1'b0, 1'b1, 1);
    clear_logs();
    @(negedge clk);
    checkOutput("t5_ireq_valid", 32'(bus0.IReqValid), 32'd1);
    checkOutput("t5_ireq_addr", bus0.IReqAddr, 32'h0);
    checkOutput("t5_empty", 32'(bus0.InstValid), 32'd0);
    checkOutput("t5_head_pc", bus0.InstPc, 32'h0);
    checkOutput("t5_head_inst", bus0.Inst, 32'h0);
    tick(6);
    checkOutput("t5_pop0", q_at(pop_pc0, 0), 32'h0);
    checkOutput("t5_pop1", q_at(pop_pc0, 1), 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
